pwm_capture: RTL

Single-channel PWM pulse decoder: the receive-side counterpart of the `pwm` generator. It measures the high time and period of an incoming PWM/servo-style signal (RC receiver channel, ESC feedback, or loopback of `pwm_out`) in system-clock ticks. Each complete period produces one-cycle `valid` results. Sits between a board input pin and the Wishbone register block (`wb_pwm` style), which reads `high_ticks`/`period_ticks` and latches `valid`/`timeout` into status bits.

---
 rtl/pwm_capture.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - single-channel PWM high-time / period decoder
//
// Purpose: measures the high time and rising-to-rising period of an
// asynchronous PWM input in clk ticks. The input passes through a 2-FF
// synchronizer and a run-length glitch filter. A three-state FSM with one
// saturating counter then timestamps the filtered edges and publishes one
// result pair per complete period.
//
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   ena           capture enable; low parks the FSM in IDLE
//   pwm_in        asynchronous PWM input
//   level         filtered, synchronized input level
//   high_ticks    last measured high time (CNT_W bits)
//   period_ticks  last measured period (CNT_W bits)
//   valid         one-cycle strobe with each new high/period pair
//   timeout       signal-loss flag (set at reset, cleared by next valid)

module pwm_capture #(
  parameter int SYS_CLK       = 50000000,
  parameter int CNT_W         = 24,
  parameter int FILT_LEN      = 4,
  parameter int TIMEOUT_TICKS = 2500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             pwm_in,
  output logic             level,
  output logic [CNT_W-1:0] high_ticks,
  output logic [CNT_W-1:0] period_ticks,
  output logic             valid,
  output logic             timeout
);

  // SYS_CLK only documents how the default TIMEOUT_TICKS was derived.
  if (FILT_LEN < 1 || SYS_CLK <= 0 ||
      longint'(TIMEOUT_TICKS) >= (longint'(1) << CNT_W) - 1) begin : g_param_check
    $error("pwm_capture: invalid parameter set");
  end

  localparam int               FW       = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0]    FILT_MAX = FW'(FILT_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT_TICKS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  logic             sync1;
  logic             sync2;
  logic [FW-1:0]    filt_cnt;
  logic             level_d;
  logic             rise;
  logic             fall;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] high_lat;

  // Input path: synchronizer, then the filter. The filter counts how long
  // the synchronized sample has disagreed with level; level follows only
  // after FILT_LEN consecutive disagreeing samples. Both polarities see the
  // same delay, so measured widths are unbiased.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      filt_cnt <= '0;
      level    <= 1'b0;
      level_d  <= 1'b0;
    end else begin
      sync1   <= pwm_in;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 != level) begin
        if (filt_cnt == FILT_MAX) begin
          level    <= sync2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + FW'(1);
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign rise    = level & ~level_d;
  assign fall    = ~level & level_d;
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

  // cnt restarts at 1 on the rise cycle, so its value on a later edge
  // cycle equals the distance in cycles between the two filtered edges.
  // Timeout uses >= so that a fall landing exactly on TIMEOUT_TICKS in HIGH
  // still leads to a timeout in LOW instead of a silently saturating count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      high_lat     <= '0;
      high_ticks   <= '0;
      period_ticks <= '0;
      valid        <= 1'b0;
      timeout      <= 1'b1;
    end else begin
      valid <= 1'b0;
      if (!ena) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt <= '0;
            if (rise) begin
              state <= HIGH;
              cnt   <= CNT_W'(1);
            end
          end
          HIGH: begin
            cnt <= cnt_inc;
            if (fall) begin
              high_lat <= cnt;
              state    <= LOW;
            end else if (cnt >= TO_CNT) begin
              timeout <= 1'b1;
              state   <= IDLE;
              cnt     <= '0;
            end
          end
          LOW: begin
            cnt <= cnt_inc;
            if (rise) begin
              period_ticks <= cnt;
              high_ticks   <= high_lat;
              valid        <= 1'b1;
              timeout      <= 1'b0;
              cnt          <= CNT_W'(1);
              state        <= HIGH;
            end else if (cnt >= TO_CNT) begin
              timeout <= 1'b1;
              state   <= IDLE;
              cnt     <= '0;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
